mc_move_scheduler: RTL and testbench
====================================

// Module: mc_move_scheduler
// PURPOSE
//  Sequences one monteCarloStat engine across the four candidate first moves (restrected=0..3) for a
//  single board. Per direction: clear engine, run until TRIALS playouts, sample total_move_count as score.
//  Reports the direction with the highest score. Sits between the top-level game loop and the engine.
// PARAMETERS
//  TRIALS    32'd64       playouts per direction before sampling (>=1)
//  WDOG_MAX  32'd1000000  max cycles per direction in RUN before forced abort
//  SEED_ALT  8'h5A        substitute seed when per-direction seed computes to 0 (xorshift lock-up)
// PORTS
//  clk                   in   1   system clock, all state on posedge
//  rst                   in   1   synchronous reset, ACTIVE-LOW (rst==0 resets)
//  start                 in   1   request; accepted only in IDLE
//  board_in              in   80  board to evaluate, latched on accepted start
//  seed_in               in   8   base seed, latched on accepted start
//  prob_in               in   3   restrect_prob for engine, latched on accepted start
//  busy                  out  1   1 from cycle after accepted start until DONE exits
//  done                  out  1   one-cycle pulse; results valid from this cycle until next accepted start
//  best_dir              out  2   winning direction
//  best_score            out  32  winning direction's total_move_count
//  timeout_flags         out  4   bit d set if direction d hit WDOG_MAX (its score forced to 0)
//  mc_rst                out  1   engine reset, active-HIGH (engine convention)
//  mc_restrected         out  2   current direction under test
//  mc_restrect_prob      out  3   latched prob_in
//  mc_initial_board      out  80  latched board_in
//  mc_seed               out  8   per-direction seed
//  mc_total_move_count   in   32  engine accumulated move count
//  mc_total_trial_count  in   32  engine completed playouts
// BEHAVIOUR
//  Reset (rst==0): state=IDLE, busy=0, done=0, best_dir=0, best_score=0, timeout_flags=0, mc_rst=1,
//   dir=0, wdog=0, latched board/seed/prob=0. Reset mid-run aborts immediately; no done pulse.
//  mc_rst=1 in IDLE, CLEAR, SAMPLE, NEXT, DONE; 0 only in RUN. Engine never runs unattended.
//  mc_seed = seed_lat ^ {dir,dir,dir,dir}; if result==0 use SEED_ALT. Registered, stable through RUN.
//  FSM:
//   IDLE : start=1 -> latch inputs, dir=0, timeout_flags=0, busy=1 -> CLEAR. start ignored elsewhere.
//   CLEAR: exactly 1 cycle, mc_rst=1, wdog=0 -> RUN.
//   RUN  : wdog++ each cycle. mc_total_trial_count>=TRIALS -> SAMPLE (score=mc_total_move_count).
//          else wdog==WDOG_MAX-1 -> SAMPLE with score=0, timeout_flags[dir]=1. Trial-count check wins
//          if both in same cycle (no timeout flag).
//   SAMPLE: 1 cycle. if dir==0 or score>best_score: best_score=score, best_dir=dir.
//           Ties keep lower dir (strict >). All four timed out -> best_dir=0, best_score=0.
//   NEXT : dir==3 -> DONE; else dir++ -> CLEAR.
//   DONE : done=1 one cycle, busy=0 -> IDLE. start in DONE cycle ignored; accepted next cycle.
//  Latency (no timeout): start accepted at cycle 0; per direction 1(CLEAR)+R_d(RUN)+1+1;
//   done at cycle 1 + sum_d(R_d+3). best_* update only in SAMPLE; hold otherwise.
//  Score is 32-bit unsigned compare; engine counts used as-is, no saturation.
// TESTING
//  T1 reset: hold rst=0 3 cycles mid-RUN -> busy=0, done=0, mc_rst=1, outputs 0, no done pulse later.
//  T2 model engine: trial_count hits 64 after 10 cycles, move counts d0=100,d1=400,d2=250,d3=399
//     -> done once, best_dir=1, best_score=400, timeout_flags=0, done at cycle 1+4*13=53.
//  T3 tie: scores 300,300,300,300 -> best_dir=0, best_score=300.
//  T4 watchdog (WDOG_MAX=20): d2 never reaches TRIALS -> timeout_flags=4'b0100, d2 score 0,
//     RUN for d2 lasts exactly 20 cycles; others evaluated normally.
//  T5 seed: seed_in=8'h55 -> mc_seed 55,00->5A(d1),FF,AA... check d1 gets SEED_ALT; start pulses
//     during busy and in DONE cycle ignored, single done per accepted start.

Source files
------------

// File: rtl/mc_move_scheduler.sv
// Move scheduler: runs one Monte-Carlo engine over the four candidate first moves of a
// board, samples each direction's accumulated move count and reports the best direction.
module mc_move_scheduler #(
  parameter logic [31:0] TRIALS   = 32'd64,
  parameter logic [31:0] WDOG_MAX = 32'd1000000,
  parameter logic [7:0]  SEED_ALT = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] board_in,
  input  logic [7:0]  seed_in,
  input  logic [2:0]  prob_in,
  output logic        busy,
  output logic        done,
  output logic [1:0]  best_dir,
  output logic [31:0] best_score,
  output logic [3:0]  timeout_flags,
  output logic        mc_rst,
  output logic [1:0]  mc_restrected,
  output logic [2:0]  mc_restrect_prob,
  output logic [79:0] mc_initial_board,
  output logic [7:0]  mc_seed,
  input  logic [31:0] mc_total_move_count,
  input  logic [31:0] mc_total_trial_count
);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StSample, StNext, StDone} state_t;

  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] score_q, score_d;
  logic [31:0] best_score_q, best_score_d;
  logic [1:0]  best_dir_q, best_dir_d;
  logic [3:0]  tflags_q, tflags_d;
  logic [79:0] board_q, board_d;
  logic [7:0]  seed_q, seed_d;
  logic [2:0]  prob_q, prob_d;
  logic [7:0]  mc_seed_q, mc_seed_d;

  // Per-direction seed; an all-zero seed would lock the engine's xorshift generator.
  function automatic logic [7:0] dir_seed(input logic [7:0] base, input logic [1:0] d);
    logic [7:0] s;
    s = base ^ {d, d, d, d};
    return (s == 8'd0) ? SEED_ALT : s;
  endfunction

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    wdog_d       = wdog_q;
    score_d      = score_q;
    best_score_d = best_score_q;
    best_dir_d   = best_dir_q;
    tflags_d     = tflags_q;
    board_d      = board_q;
    seed_d       = seed_q;
    prob_d       = prob_q;
    mc_seed_d    = mc_seed_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          board_d   = board_in;
          seed_d    = seed_in;
          prob_d    = prob_in;
          dir_d     = 2'd0;
          tflags_d  = 4'd0;
          mc_seed_d = dir_seed(seed_in, 2'd0);
          state_d   = StClear;
        end
      end
      StClear: begin
        wdog_d  = 32'd0;
        state_d = StRun;
      end
      StRun: begin
        wdog_d = wdog_q + 32'd1;
        // A finished trial count takes priority over a simultaneous watchdog expiry.
        if (mc_total_trial_count >= TRIALS) begin
          score_d = mc_total_move_count;
          state_d = StSample;
        end else if (wdog_q == WDOG_MAX - 32'd1) begin
          score_d         = 32'd0;
          tflags_d[dir_q] = 1'b1;
          state_d         = StSample;
        end
      end
      StSample: begin
        // Strict compare keeps the lowest direction on ties.
        if (dir_q == 2'd0 || score_q > best_score_q) begin
          best_score_d = score_q;
          best_dir_d   = dir_q;
        end
        state_d = StNext;
      end
      StNext: begin
        if (dir_q == 2'd3) begin
          state_d = StDone;
        end else begin
          dir_d     = dir_q + 2'd1;
          mc_seed_d = dir_seed(seed_q, dir_q + 2'd1);
          state_d   = StClear;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      dir_q        <= 2'd0;
      wdog_q       <= 32'd0;
      score_q      <= 32'd0;
      best_score_q <= 32'd0;
      best_dir_q   <= 2'd0;
      tflags_q     <= 4'd0;
      board_q      <= 80'd0;
      seed_q       <= 8'd0;
      prob_q       <= 3'd0;
      mc_seed_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      wdog_q       <= wdog_d;
      score_q      <= score_d;
      best_score_q <= best_score_d;
      best_dir_q   <= best_dir_d;
      tflags_q     <= tflags_d;
      board_q      <= board_d;
      seed_q       <= seed_d;
      prob_q       <= prob_d;
      mc_seed_q    <= mc_seed_d;
    end
  end

  // The engine is held in reset everywhere except RUN.
  always_comb begin
    busy             = (state_q != StIdle);
    done             = (state_q == StDone);
    mc_rst           = (state_q != StRun);
    best_dir         = best_dir_q;
    best_score       = best_score_q;
    timeout_flags    = tflags_q;
    mc_restrected    = dir_q;
    mc_restrect_prob = prob_q;
    mc_initial_board = board_q;
    mc_seed          = mc_seed_q;
  end

endmodule

// File: tb/tb_mc_move_scheduler.sv
// Bench for mc_move_scheduler: behavioural engine stand-in plus a per-test reference model.
module tb_mc_move_scheduler;

  localparam logic [31:0] TRIALS = 32'd64;
  localparam int          WDOG   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [79:0] board_in = 80'd0;
  logic [7:0]  seed_in = 8'd0;
  logic [2:0]  prob_in = 3'd0;
  logic        busy, done, mc_rst;
  logic [1:0]  best_dir, mc_restrected;
  logic [31:0] best_score, mc_total_move_count, mc_total_trial_count;
  logic [3:0]  timeout_flags;
  logic [2:0]  mc_restrect_prob;
  logic [79:0] mc_initial_board;
  logic [7:0]  mc_seed;

  mc_move_scheduler #(
    .TRIALS  (TRIALS),
    .WDOG_MAX(32'd20),
    .SEED_ALT(8'h5A)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .board_in            (board_in),
    .seed_in             (seed_in),
    .prob_in             (prob_in),
    .busy                (busy),
    .done                (done),
    .best_dir            (best_dir),
    .best_score          (best_score),
    .timeout_flags       (timeout_flags),
    .mc_rst              (mc_rst),
    .mc_restrected       (mc_restrected),
    .mc_restrect_prob    (mc_restrect_prob),
    .mc_initial_board    (mc_initial_board),
    .mc_seed             (mc_seed),
    .mc_total_move_count (mc_total_move_count),
    .mc_total_trial_count(mc_total_trial_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Engine stand-in: direction d completes TRIALS playouts in its eng_len[d]-th RUN cycle.
  logic [31:0] eng_len [4];
  logic [31:0] eng_score [4];
  logic [31:0] eng_cnt = 32'd0;

  always @(posedge clk) begin
    if (mc_rst) eng_cnt <= 32'd0;
    else        eng_cnt <= eng_cnt + 32'd1;
  end

  always_comb begin
    mc_total_trial_count = (eng_cnt + 32'd1 >= eng_len[mc_restrected]) ? TRIALS : eng_cnt;
    mc_total_move_count  = eng_score[mc_restrected];
  end

  function automatic logic [7:0] exp_seed_fn(input logic [7:0] base, input logic [1:0] d);
    logic [7:0] m;
    logic [7:0] s;
    m = 8'(d) * 8'h55;
    s = base ^ m;
    return (s == 8'd0) ? 8'h5A : s;
  endfunction

  // Monitor: counts RUN cycles per direction and done pulses, checks engine drive during RUN.
  logic [79:0] exp_board = 80'd0;
  logic [7:0]  exp_seed = 8'd0;
  logic [2:0]  exp_prob = 3'd0;
  int run_len [4] = '{0, 0, 0, 0};
  int done_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst && !mc_rst) begin
      run_len[mc_restrected]++;
      check_eq("run_seed", mc_seed, exp_seed_fn(exp_seed, mc_restrected));
      check_eq("run_board", mc_initial_board, exp_board);
      check_eq("run_prob", mc_restrect_prob, exp_prob);
    end
  end

  task automatic run_test(input logic [79:0] b, input logic [7:0] s, input logic [2:0] p);
    int          base [4];
    int          exp_run [4];
    logic [31:0] sc [4];
    logic [3:0]  eflags;
    logic [1:0]  ebd;
    logic [31:0] ebs;
    int          edone;
    int          done_base;
    int          cyc;
    edone  = 1;
    eflags = 4'd0;
    for (int d = 0; d < 4; d++) begin
      if (eng_len[d] > 32'(WDOG)) begin
        exp_run[d] = WDOG;
        sc[d]      = 32'd0;
        eflags[d]  = 1'b1;
      end else begin
        exp_run[d] = int'(eng_len[d]);
        sc[d]      = eng_score[d];
      end
      edone += exp_run[d] + 3;
    end
    ebd = 2'd0;
    ebs = sc[0];
    for (int d = 1; d < 4; d++) begin
      if (sc[d] > ebs) begin
        ebs = sc[d];
        ebd = 2'(d);
      end
    end
    @(negedge clk);
    board_in = b; seed_in = s; prob_in = p; start = 1'b1;
    exp_board = b; exp_seed = s; exp_prob = p;
    for (int d = 0; d < 4; d++) base[d] = run_len[d];
    done_base = done_cnt;
    @(negedge clk);
    cyc   = 1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1'b1);
    while (!done && cyc < 500) begin
      start    = 1'($urandom_range(0, 1));
      board_in = 80'({$urandom, $urandom, $urandom});
      seed_in  = 8'($urandom);
      prob_in  = 3'($urandom);
      @(negedge clk);
      cyc++;
    end
    check_eq("done_cycle", cyc, edone);
    check_eq("busy_in_done", busy, 1'b1);
    check_eq("best_dir", best_dir, ebd);
    check_eq("best_score", best_score, ebs);
    check_eq("timeout_flags", timeout_flags, eflags);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    @(negedge clk);
    check_eq("done_start_ignored", busy, 1'b0);
    check_eq("best_score_held", best_score, ebs);
    for (int d = 0; d < 4; d++) check_eq($sformatf("run_len_d%0d", d), run_len[d] - base[d],
                                         exp_run[d]);
    check_eq("done_count", done_cnt - done_base, 1);
  endtask

  task automatic set_eng(input int l0, input int l1, input int l2, input int l3,
                         input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3);
    eng_len[0] = 32'(l0); eng_len[1] = 32'(l1); eng_len[2] = 32'(l2); eng_len[3] = 32'(l3);
    eng_score[0] = s0; eng_score[1] = s1; eng_score[2] = s2; eng_score[3] = s3;
  endtask

  function automatic logic [31:0] pick_score();
    case ($urandom_range(0, 4))
      0:       return 32'd300;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dc;
    set_eng(10, 10, 10, 10, 32'd100, 32'd400, 32'd250, 32'd399);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_mc_rst", mc_rst, 1'b1);
    check_eq("rst_best", {best_dir, best_score, timeout_flags}, 38'd0);
    rst = 1'b1;

    // Basic ranking, latency 53
    run_test(80'h1234_5678_9ABC_DEF0_1357, 8'h12, 3'd5);
    // Reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; board_in = 80'hABCD; seed_in = 8'h33; prob_in = 3'd2;
    exp_board = board_in; exp_seed = seed_in; exp_prob = prob_in;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("pre_rst_in_run", mc_rst, 1'b0);
    rst = 1'b0;
    dc  = done_cnt;
    repeat (3) @(negedge clk);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_mc_rst", mc_rst, 1'b1);
    check_eq("midrst_best", {best_dir, best_score, timeout_flags}, 38'd0);
    check_eq("midrst_latched", {mc_initial_board, mc_restrect_prob, mc_restrected}, 85'd0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("midrst_no_done", done_cnt - dc, 0);
    check_eq("midrst_idle", busy, 1'b0);

    // Ties keep lowest direction
    set_eng(7, 3, 12, 1, 32'd300, 32'd300, 32'd300, 32'd300);
    run_test(80'hFEED, 8'h01, 3'd7);
    // Direction 2 times out
    set_eng(5, 8, 1000, 4, 32'd10, 32'd20, 32'd999, 32'd15);
    run_test(80'hBEEF, 8'hC3, 3'd1);
    // Seed lock-up substitution on direction 1; boundary run length equal to watchdog
    set_eng(20, 2, 1, 20, 32'd5, 32'd6, 32'd7, 32'd7);
    run_test(80'h55, 8'h55, 3'd0);
    // Everything times out
    set_eng(1000, 1000, 1000, 1000, 32'd1, 32'd2, 32'd3, 32'd4);
    run_test(80'h1, 8'h00, 3'd3);

    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        eng_len[d]   = ($urandom_range(0, 4) == 0) ? 32'd1000 : 32'($urandom_range(1, 20));
        eng_score[d] = pick_score();
      end
      run_test(80'({$urandom, $urandom, $urandom}), 8'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "simulation time limit");
  end

endmodule
